key_debouncer: RTL and testbench

//  Conditions the raw push-button bank before it reaches the clock-control logic,

---
 rtl/key_debouncer_pkg.sv | 33 +++
 rtl/key_debounce_cell.sv | 82 ++++++++
 rtl/key_debouncer.sv | 39 +++
 tb/tb_key_debouncer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/key_debouncer_pkg.sv
//------------------------------------------------------------------------------
// key_debouncer_pkg
//   Shared clock constants, debounce defaults and helpers for the key
//   conditioning logic.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package key_debouncer_pkg;

    localparam int CLK_50_HZ         = 50_000_000;
    localparam int DB_MS_DEFAULT     = 10;
    // 10 ms of stable level at 50 MHz
    localparam int DB_CYCLES_DEFAULT = (CLK_50_HZ / 1000) * DB_MS_DEFAULT;

    typedef enum logic [1:0] {
        CNT_CLEAR  = 2'd0,
        CNT_STEP   = 2'd1,
        CNT_ACCEPT = 2'd2
    } cnt_action_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((longint'(1) << r) < longint'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce_cell.sv
//------------------------------------------------------------------------------
// key_debounce_cell
//   Single-key synchroniser, stability counter, debounced level and strobes.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module key_debounce_cell
    import key_debouncer_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic iCLK_50,
    input  logic Reset,
    input  logic iKEY_raw,
    output logic oKEY,
    output logic oPress,
    output logic oRelease
);

    localparam int                CNT_W      = clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0]  c_CNT_TERM = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_key;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_release;
    cnt_action_t      w_action;

    // Counter only advances while the synchronised input disagrees with the
    // accepted level; any agreement restarts the stability window.
    always_comb begin
        w_action = CNT_CLEAR;
        if (r_sync2 != r_key) begin
            if (r_cnt >= c_CNT_TERM) begin
                w_action = CNT_ACCEPT;
            end else begin
                w_action = CNT_STEP;
            end
        end
    end

    always_ff @(posedge iCLK_50 or posedge Reset) begin
        if (Reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_key     <= 1'b1;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= iKEY_raw;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (w_action)
                CNT_STEP: begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
                CNT_ACCEPT: begin
                    r_key     <= r_sync2;
                    r_cnt     <= '0;
                    r_press   <= ~r_sync2;
                    r_release <= r_sync2;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign oKEY     = r_key;
    assign oPress   = r_press;
    assign oRelease = r_release;

endmodule

`default_nettype wire

// File: rtl/key_debouncer.sv
//------------------------------------------------------------------------------
// key_debouncer
//   Debounces the push-button bank into clean active-low levels and strobes.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int NKEYS     = 4,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic             iCLK_50,
    input  logic             Reset,
    input  logic [NKEYS-1:0] iKEY_raw,
    output logic [NKEYS-1:0] oKEY,
    output logic [NKEYS-1:0] oPress,
    output logic [NKEYS-1:0] oRelease
);

    generate
        for (genvar g = 0; g < NKEYS; g++) begin : g_key
            key_debounce_cell #(
                .DB_CYCLES (DB_CYCLES)
            ) u_cell (
                .iCLK_50  (iCLK_50),
                .Reset    (Reset),
                .iKEY_raw (iKEY_raw[g]),
                .oKEY     (oKEY[g]),
                .oPress   (oPress[g]),
                .oRelease (oRelease[g])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_key_debouncer.sv
//------------------------------------------------------------------------------
// tb_key_debouncer
//   Directed scoreboard bench for key_debouncer with a short debounce window.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_key_debouncer;

    localparam int NKEYS     = 4;
    localparam int DB_CYCLES = 4;
    localparam int c_LAT     = DB_CYCLES + 2;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
    } evt_t;

    logic       iCLK_50;
    logic       Reset;
    logic [3:0] iKEY_raw;
    logic [3:0] oKEY;
    logic [3:0] oPress;
    logic [3:0] oRelease;

    int   cyc;
    int   errors;
    int   checks;
    bit   mon_en;
    evt_t q[$];
    logic [3:0] exp_key;
    logic [3:0] exp_p;
    logic [3:0] exp_r;

    key_debouncer #(
        .NKEYS     (NKEYS),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .iCLK_50  (iCLK_50),
        .Reset    (Reset),
        .iKEY_raw (iKEY_raw),
        .oKEY     (oKEY),
        .oPress   (oPress),
        .oRelease (oRelease)
    );

    initial iCLK_50 = 1'b0;
    always #5 iCLK_50 = ~iCLK_50;

    initial cyc = 0;
    always @(posedge iCLK_50) cyc++;

    // Expected output change for an edge driven now, seen after c_LAT edges.
    task automatic push_evt(input logic [3:0] press, input logic [3:0] rel);
        evt_t e;
        e.cyc   = cyc + c_LAT;
        e.press = press;
        e.rel   = rel;
        q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge iCLK_50);
    endtask

    always @(negedge iCLK_50) begin
        evt_t e;
        #2;
        exp_p = 4'h0;
        exp_r = 4'h0;
        if (Reset) begin
            q.delete();
            exp_key = 4'hF;
        end else if (q.size() > 0 && q[0].cyc == cyc) begin
            e       = q.pop_front();
            exp_p   = e.press;
            exp_r   = e.rel;
            exp_key = (exp_key & ~e.press) | e.rel;
        end
        if (mon_en) begin
            checks++;
            assert (oKEY === exp_key) else begin
                errors++;
                $error("FAIL oKEY cyc=%0d: got %h expected %h", cyc, oKEY, exp_key);
            end
            checks++;
            assert (oPress === exp_p) else begin
                errors++;
                $error("FAIL oPress cyc=%0d: got %h expected %h", cyc, oPress, exp_p);
            end
            checks++;
            assert (oRelease === exp_r) else begin
                errors++;
                $error("FAIL oRelease cyc=%0d: got %h expected %h", cyc, oRelease, exp_r);
            end
        end
    end

    initial begin
        errors   = 0;
        checks   = 0;
        mon_en   = 1'b0;
        exp_key  = 4'hF;
        Reset    = 1'b0;
        iKEY_raw = 4'h0;

        // 1: reset with all keys held, then release
        @(negedge iCLK_50);
        Reset  = 1'b1;
        mon_en = 1'b1;
        wait_cycles(3);
        Reset = 1'b0;
        push_evt(4'hF, 4'h0);
        wait_cycles(10);
        iKEY_raw = 4'hF;
        push_evt(4'h0, 4'hF);
        wait_cycles(10);

        // 2: clean press and release of key 3
        iKEY_raw[3] = 1'b0;
        push_evt(4'h8, 4'h0);
        wait_cycles(20);
        iKEY_raw[3] = 1'b1;
        push_evt(4'h0, 4'h8);
        wait_cycles(10);

        // 3: short glitch on key 1
        iKEY_raw[1] = 1'b0;
        wait_cycles(3);
        iKEY_raw[1] = 1'b1;
        wait_cycles(10);

        // 4: bouncing key 2 settling low, then released
        for (int i = 0; i < 10; i++) begin
            iKEY_raw[2] = ~iKEY_raw[2];
            wait_cycles(2);
        end
        iKEY_raw[2] = 1'b0;
        push_evt(4'h4, 4'h0);
        wait_cycles(12);
        iKEY_raw[2] = 1'b1;
        push_evt(4'h0, 4'h4);
        wait_cycles(10);

        // 5: simultaneous press of keys 0 and 2
        iKEY_raw = 4'hA;
        push_evt(4'h5, 4'h0);
        wait_cycles(10);
        iKEY_raw = 4'hF;
        push_evt(4'h0, 4'h5);
        wait_cycles(10);

        // 6: reset during the count discards progress
        iKEY_raw[3] = 1'b0;
        push_evt(4'h8, 4'h0);
        wait_cycles(3);
        Reset = 1'b1;
        wait_cycles(2);
        Reset = 1'b0;
        push_evt(4'h8, 4'h0);
        wait_cycles(10);
        iKEY_raw[3] = 1'b1;
        push_evt(0, 4'h8);
        wait_cycles(10);

        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL pending_events: got %0d expected 0", q.size());
        end

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
